// File: rtl/maxpool_2x2_linebuf.sv
// 2x2 stride-2 max pooling over a raster-order, 3-channel pixel stream.
// Stage p0 tracks the pixel position, holds the even-column sample of each
// horizontal pair and parks the top-row pair maximum in a half-width line
// buffer. Stage p1 registers the window maximum together with its valid and
// end-of-frame flags, one clock after the pixel that completes the window.
module maxpool_2x2_linebuf #(
    parameter int CONV_BIT = 12,
    parameter int IMG_W    = 24,
    parameter int IMG_H    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [CONV_BIT-1:0] data_in_1,
    input  logic [CONV_BIT-1:0] data_in_2,
    input  logic [CONV_BIT-1:0] data_in_3,
    output logic [CONV_BIT-1:0] pool_out_1,
    output logic [CONV_BIT-1:0] pool_out_2,
    output logic [CONV_BIT-1:0] pool_out_3,
    output logic                valid_out,
    output logic                frame_done
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Samples are post-ReLU magnitudes, so every comparison is unsigned and
    // full width; ties simply return the shared value.
    function automatic logic [CONV_BIT-1:0] umax2(
        input logic [CONV_BIT-1:0] a,
        input logic [CONV_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CONV_BIT-1:0] umax3(
        input logic [CONV_BIT-1:0] a,
        input logic [CONV_BIT-1:0] b,
        input logic [CONV_BIT-1:0] c
    );
        return umax2(umax2(a, b), c);
    endfunction

    // ---------------- stage p0: position, pair hold, line buffer ----------------
    logic [COL_W-1:0]    col_p0;
    logic [ROW_W-1:0]    row_p0;
    logic [CONV_BIT-1:0] hold_p0_1;
    logic [CONV_BIT-1:0] hold_p0_2;
    logic [CONV_BIT-1:0] hold_p0_3;

    // Line buffers carry no reset: each entry is rewritten in an even row
    // before the following odd row reads it, even after an aborted frame.
    logic [CONV_BIT-1:0] lbuf_p0_1 [HALF_W];
    logic [CONV_BIT-1:0] lbuf_p0_2 [HALF_W];
    logic [CONV_BIT-1:0] lbuf_p0_3 [HALF_W];

    logic                odd_col_p0;
    logic                odd_row_p0;
    logic                col_last_p0;
    logic                row_last_p0;
    logic                lbuf_wr_p0;
    logic                win_done_p0;
    logic                frame_end_p0;
    logic [IDX_W-1:0]    lbuf_idx_p0;
    logic [CONV_BIT-1:0] pair_max_p0_1;
    logic [CONV_BIT-1:0] pair_max_p0_2;
    logic [CONV_BIT-1:0] pair_max_p0_3;
    logic [CONV_BIT-1:0] win_max_p0_1;
    logic [CONV_BIT-1:0] win_max_p0_2;
    logic [CONV_BIT-1:0] win_max_p0_3;

    // Decode the current pixel position and form the pair / window maxima.
    always_comb begin
        odd_col_p0   = col_p0[0];
        odd_row_p0   = row_p0[0];
        col_last_p0  = (col_p0 == COL_LAST);
        row_last_p0  = (row_p0 == ROW_LAST);
        lbuf_idx_p0  = IDX_W'(col_p0 >> 1);

        lbuf_wr_p0   = valid_in &  odd_col_p0 & ~odd_row_p0;
        win_done_p0  = valid_in &  odd_col_p0 &  odd_row_p0;
        frame_end_p0 = col_last_p0 & row_last_p0;

        pair_max_p0_1 = umax2(hold_p0_1, data_in_1);
        pair_max_p0_2 = umax2(hold_p0_2, data_in_2);
        pair_max_p0_3 = umax2(hold_p0_3, data_in_3);

        win_max_p0_1 = umax3(lbuf_p0_1[lbuf_idx_p0], hold_p0_1, data_in_1);
        win_max_p0_2 = umax3(lbuf_p0_2[lbuf_idx_p0], hold_p0_2, data_in_2);
        win_max_p0_3 = umax3(lbuf_p0_3[lbuf_idx_p0], hold_p0_3, data_in_3);
    end

    // Raster position counters; they move only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_p0 <= '0;
            row_p0 <= '0;
        end else if (valid_in) begin
            if (col_last_p0) begin
                col_p0 <= '0;
                if (row_last_p0) begin
                    row_p0 <= '0;
                end else begin
                    row_p0 <= row_p0 + ROW_W'(1);
                end
            end else begin
                col_p0 <= col_p0 + COL_W'(1);
            end
        end
    end

    // Capture the left sample of each horizontal pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_p0_1 <= '0;
            hold_p0_2 <= '0;
            hold_p0_3 <= '0;
        end else if (valid_in && !odd_col_p0) begin
            hold_p0_1 <= data_in_1;
            hold_p0_2 <= data_in_2;
            hold_p0_3 <= data_in_3;
        end
    end

    // Park the top-row pair maximum until the matching bottom-row pair arrives.
    always_ff @(posedge clk) begin
        if (lbuf_wr_p0) begin
            lbuf_p0_1[lbuf_idx_p0] <= pair_max_p0_1;
            lbuf_p0_2[lbuf_idx_p0] <= pair_max_p0_2;
            lbuf_p0_3[lbuf_idx_p0] <= pair_max_p0_3;
        end
    end

    // ---------------- stage p1: registered window result ----------------
    logic                vld_p1;
    logic                fdone_p1;
    logic [CONV_BIT-1:0] pool_p1_1;
    logic [CONV_BIT-1:0] pool_p1_2;
    logic [CONV_BIT-1:0] pool_p1_3;

    // Register the completed window; results persist until the next window,
    // and a reset in the completing cycle drops that window entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            fdone_p1  <= 1'b0;
            pool_p1_1 <= '0;
            pool_p1_2 <= '0;
            pool_p1_3 <= '0;
        end else begin
            vld_p1   <= win_done_p0;
            fdone_p1 <= win_done_p0 & frame_end_p0;
            if (win_done_p0) begin
                pool_p1_1 <= win_max_p0_1;
                pool_p1_2 <= win_max_p0_2;
                pool_p1_3 <= win_max_p0_3;
            end
        end
    end

    assign valid_out  = vld_p1;
    assign frame_done = fdone_p1;
    assign pool_out_1 = pool_p1_1;
    assign pool_out_2 = pool_p1_2;
    assign pool_out_3 = pool_p1_3;

endmodule

// File: tb/tb_maxpool_2x2_linebuf.sv
// Directed bench for maxpool_2x2_linebuf on a 4x4 frame, 12-bit samples.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// one cycle after the pixel that should produce them.
module tb_maxpool_2x2_linebuf;

    localparam int CB = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [CB-1:0] data_in_1 = '0;
    logic [CB-1:0] data_in_2 = '0;
    logic [CB-1:0] data_in_3 = '0;
    logic [CB-1:0] pool_out_1;
    logic [CB-1:0] pool_out_2;
    logic [CB-1:0] pool_out_3;
    logic          valid_out;
    logic          frame_done;

    maxpool_2x2_linebuf #(
        .CONV_BIT (CB),
        .IMG_W    (4),
        .IMG_H    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in_1  (data_in_1),
        .data_in_2  (data_in_2),
        .data_in_3  (data_in_3),
        .pool_out_1 (pool_out_1),
        .pool_out_2 (pool_out_2),
        .pool_out_3 (pool_out_3),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Hand-computed window maxima of the 4x4 ramp (ch1 = r*4+c) and of the
    // reversed ramp (ch2 = 15-(r*4+c)), in pooled raster order.
    localparam int RAMP1_EXP [4] = '{5, 7, 13, 15};
    localparam int RAMP2_EXP [4] = '{15, 13, 7, 5};

    int checks   = 0;
    int failures = 0;

    // Expectation for the next sample point, and the value pool_out must hold.
    logic          pend_v  = 1'b0;
    logic          pend_fd = 1'b0;
    logic [CB-1:0] pend_1  = '0;
    logic [CB-1:0] pend_2  = '0;
    logic [CB-1:0] pend_3  = '0;
    logic [CB-1:0] last_1  = '0;
    logic [CB-1:0] last_2  = '0;
    logic [CB-1:0] last_3  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("valid_out", 32'(valid_out), 32'(pend_v));
        chk("frame_done", 32'(frame_done), 32'(pend_v & pend_fd));
        if (pend_v) begin
            last_1 = pend_1;
            last_2 = pend_2;
            last_3 = pend_3;
        end
        chk("pool_out_1", 32'(pool_out_1), 32'(last_1));
        chk("pool_out_2", 32'(pool_out_2), 32'(last_2));
        chk("pool_out_3", 32'(pool_out_3), 32'(last_3));
    endtask

    // One clock: check what the previous cycle produced, then drive this cycle.
    task automatic tick(input logic vin, input logic [CB-1:0] a, input logic [CB-1:0] b,
                        input logic [CB-1:0] c, input logic cmp, input logic [CB-1:0] e1,
                        input logic [CB-1:0] e2, input logic [CB-1:0] e3, input logic efd);
        @(negedge clk);
        check_out();
        rst       = 1'b0;
        valid_in  = vin;
        data_in_1 = a;
        data_in_2 = b;
        data_in_3 = c;
        pend_v    = cmp;
        pend_fd   = cmp & efd;
        pend_1    = e1;
        pend_2    = e2;
        pend_3    = e3;
    endtask

    // One clock with reset asserted; all outputs are expected to clear.
    task automatic rst_tick(input logic vin, input logic [CB-1:0] a, input logic [CB-1:0] b,
                            input logic [CB-1:0] c);
        @(negedge clk);
        check_out();
        rst       = 1'b1;
        valid_in  = vin;
        data_in_1 = a;
        data_in_2 = b;
        data_in_3 = c;
        pend_v    = 1'b0;
        pend_fd   = 1'b0;
        last_1    = '0;
        last_2    = '0;
        last_3    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, CB'($urandom), CB'($urandom), CB'($urandom), 1'b0, '0, '0, '0, 1'b0);
    endtask

    // mode 0: ramp (ch1 up, ch2 down, ch3 constant 0x800), values + off.
    // mode 1: ch2 zero except one 0xFFF corner, corner rotated per window.
    // gap_max > 0 inserts idle cycles before pixels; npix truncates the frame.
    task automatic send_frame(input int off, input int gap_max, input int mode, input int npix);
        int k = 0;
        int p = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int idx = r * 4 + c;
                int a, b, d, e1, e2, e3;
                logic cmp;
                if (p >= npix) return;
                p++;
                if (gap_max > 0) begin
                    idle((c % 2 == 0) ? 1 : $urandom_range(gap_max, 0));
                end
                if (mode == 0) begin
                    a = off + idx;
                    b = off + 15 - idx;
                    d = 'h800;
                end else begin
                    a = 0;
                    b = (((r % 2) * 2 + (c % 2)) == ((r / 2) * 2 + (c / 2))) ? 'hFFF : 0;
                    d = 0;
                end
                cmp = (r % 2 == 1) && (c % 2 == 1);
                e1 = 0;
                e2 = 0;
                e3 = 0;
                if (cmp) begin
                    if (mode == 0) begin
                        e1 = off + RAMP1_EXP[k];
                        e2 = off + RAMP2_EXP[k];
                        e3 = 'h800;
                    end else begin
                        e2 = 'hFFF;
                    end
                end
                tick(1'b1, CB'(a), CB'(b), CB'(d), cmp, CB'(e1), CB'(e2), CB'(e3), (k == 3));
                if (cmp) k++;
            end
        end
    endtask

    initial begin
        // Reset state, with pixels presented while reset is held.
        repeat (2) @(posedge clk);
        rst_tick(1'b1, 12'h123, 12'h456, 12'h789);
        rst_tick(1'b1, 12'hABC, 12'hDEF, 12'h111);

        // Continuous ramp frame.
        send_frame(0, 0, 0, 16);
        idle(2);

        // Single hot corner per window on ch2.
        send_frame(0, 0, 1, 16);
        idle(2);

        // Same ramp with idle gaps between pixels.
        send_frame(0, 5, 0, 16);
        idle(2);

        // Two frames back to back, second offset by 100.
        send_frame(0, 0, 0, 16);
        send_frame(100, 0, 0, 16);
        idle(2);

        // Abort a frame: five pixels, then reset lands on the window-completing
        // sixth pixel, then a clean ramp frame.
        send_frame(0, 0, 0, 5);
        rst_tick(1'b1, 12'd5, 12'd10, 12'h800);
        rst_tick(1'b0, 12'd0, 12'd0, 12'd0);
        send_frame(0, 0, 0, 16);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
